// File: rtl/audio_frame_pacer_if.sv
`default_nettype none
// ------------------------------------------------------------------
// audio_frame_pacer_if : DSP-side and audio-core-side frame handshakes
// Rev 1.0
// ------------------------------------------------------------------
interface audio_frame_pacer_if #(
  parameter int DATA_W = 24
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_left;
  logic [DATA_W-1:0] in_right;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_left;
  logic [DATA_W-1:0] out_right;

  modport master (
    output in_valid, in_left, in_right, out_ready,
    input  in_ready, out_valid, out_left, out_right
  );

  modport slave (
    input  in_valid, in_left, in_right, out_ready,
    output in_ready, out_valid, out_left, out_right
  );
endinterface
`default_nettype wire

// File: rtl/audio_frame_pacer.sv
`default_nettype none
// ------------------------------------------------------------------
// audio_frame_pacer : stereo frame FIFO released one frame per sample tick
// Rev 1.0
// ------------------------------------------------------------------
module audio_frame_pacer #(
  parameter int DATA_W     = 24,
  parameter int DEPTH_LOG2 = 4,
  parameter int DIV        = 1042
) (
  input  wire logic              clk,
  input  wire logic              reset_n,
  input  wire logic              enable,
  audio_frame_pacer_if.slave     bus,
  output logic [DEPTH_LOG2:0]    level,
  output logic [15:0]            underrun_count
);

  localparam int                  DEPTH      = 1 << DEPTH_LOG2;
  localparam int                  CNT_W      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(DIV - 1);
  localparam logic [DEPTH_LOG2:0] LEVEL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [CNT_W-1:0]      div_cnt_q,   div_cnt_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q,    wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q,    rd_ptr_d;
  logic [DEPTH_LOG2:0]   level_q,     level_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_W-1:0]     out_left_q,  out_left_d;
  logic [DATA_W-1:0]     out_right_q, out_right_d;
  logic [15:0]           underrun_q,  underrun_d;

  logic [2*DATA_W-1:0]   mem_q [DEPTH];

  logic tick;
  logic wr_en;
  logic pop;
  logic out_free;
  logic fifo_empty;

  assign tick       = enable && (div_cnt_q == CNT_LAST);
  assign fifo_empty = (level_q == '0);
  assign out_free   = !out_valid_q || bus.out_ready;
  // Full is judged on the registered level only, so a same-cycle pop never frees a slot early.
  assign bus.in_ready = (level_q != LEVEL_FULL);
  assign wr_en      = bus.in_valid && bus.in_ready;
  assign pop        = tick && out_free && !fifo_empty;

  always_comb begin
    div_cnt_d   = div_cnt_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    out_valid_d = out_valid_q;
    out_left_d  = out_left_q;
    out_right_d = out_right_q;
    underrun_d  = underrun_q;

    if (enable) begin
      div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
    end

    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    case ({wr_en, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    // A tick that finds the output register occupied is simply dropped.
    if (tick && out_free) begin
      out_valid_d = 1'b1;
      if (fifo_empty) begin
        out_left_d  = '0;
        out_right_d = '0;
        if (underrun_q != 16'hFFFF) begin
          underrun_d = underrun_q + 16'd1;
        end
      end else begin
        {out_left_d, out_right_d} = mem_q[rd_ptr_q];
      end
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      out_valid_q <= 1'b0;
      out_left_q  <= '0;
      out_right_q <= '0;
      underrun_q  <= '0;
    end else begin
      div_cnt_q   <= div_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      out_valid_q <= out_valid_d;
      out_left_q  <= out_left_d;
      out_right_q <= out_right_d;
      underrun_q  <= underrun_d;
    end
  end

  // Frame storage needs no reset: occupancy is tracked by the pointers and level.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= {bus.in_left, bus.in_right};
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_left   = out_left_q;
  assign bus.out_right  = out_right_q;
  assign level          = level_q;
  assign underrun_count = underrun_q;

endmodule
`default_nettype wire
